// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the UART transmit buffer: FSM encoding, data width
// and the inter-frame gap defaults for each supported baud rate.
package uart_tx_buffer_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        BAUD_9600   = 2'd0,
        BAUD_19200  = 2'd1,
        BAUD_57600  = 2'd2,
        BAUD_115200 = 2'd3
    } baud_sel_e;

    // Gap must exceed three bclk periods so the transmitter's ready edge
    // detector sees tx_ready low long enough between frames.
    localparam int GAP_9600   = 32768;
    localparam int GAP_19200  = 16384;
    localparam int GAP_57600  = 8192;
    localparam int GAP_115200 = 4096;

    function automatic int gap_cycles_for(input baud_sel_e sel);
        int gap;
        case (sel)
            BAUD_9600:   gap = GAP_9600;
            BAUD_19200:  gap = GAP_19200;
            BAUD_57600:  gap = GAP_57600;
            BAUD_115200: gap = GAP_115200;
            default:     gap = GAP_9600;
        endcase
        return gap;
    endfunction

endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Byte FIFO with registered occupancy flags and a sticky overflow flag.
// Full is judged on the registered count, i.e. before any same-cycle pop.
module sync_fifo
    import uart_tx_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    input  logic              ovf_clr,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              push_s, pop_s;

    // Next-state for storage, pointers, occupancy and the sticky overflow flag.
    always_comb begin
        push_s   = wr_en & ~full_q;
        pop_s    = rd_en & ~empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == (ADDR_W+1)'(DEPTH));
        empty_d = (count_d == (ADDR_W+1)'(0));

        // A dropped write sets the flag even if a clear arrives together.
        if (wr_en && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_q <= {ADDR_W{1'b0}};
            rd_ptr_q <= {ADDR_W{1'b0}};
            count_q  <= {(ADDR_W+1){1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit front end: host FIFO, tx_status synchroniser and the
// request/busy/gap handshake FSM feeding the UART transmitter.
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = gap_cycles_for(BAUD_9600)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              ovf_clr,
    input  logic              tx_status,
    output logic              tx_ready,
    output logic [DATA_W-1:0] tx_byte
);

    localparam int              GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    logic              sync1_q, sync1_d;
    logic              stat_q, stat_d;
    logic              stat_s;
    tx_state_e         state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
    logic              tx_ready_q, tx_ready_d;
    logic              pop_s;
    logic              fifo_empty_s;
    logic [DATA_W-1:0] fifo_rd_data_s;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop_s),
        .rd_data  (fifo_rd_data_s),
        .ovf_clr  (ovf_clr),
        .full     (full),
        .empty    (fifo_empty_s),
        .count    (count),
        .overflow (overflow)
    );

    // Two-stage synchroniser path for the bclk-domain busy flag.
    always_comb begin
        sync1_d = tx_status;
        stat_d  = sync1_q;
    end

    assign stat_s = stat_q;

    // Handshake FSM: pop on IDLE->REQ, hold until busy, wait out the frame and gap.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        tx_byte_d = tx_byte_q;
        pop_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s && !stat_s) begin
                    pop_s     = 1'b1;
                    tx_byte_d = fifo_rd_data_s;
                    state_d   = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (stat_s) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_BUSY: begin
                if (!stat_s) begin
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(0)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_ready_d = (state_d == ST_REQ);
    end

    // Control registers; reset drops tx_ready immediately, even mid-frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            stat_q     <= 1'b0;
            state_q    <= ST_IDLE;
            gap_q      <= {GAP_W{1'b0}};
            tx_byte_q  <= {DATA_W{1'b0}};
            tx_ready_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            stat_q     <= stat_d;
            state_q    <= state_d;
            gap_q      <= gap_d;
            tx_byte_q  <= tx_byte_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign empty    = fifo_empty_s;
    assign tx_ready = tx_ready_q;
    assign tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer with a behavioural transmitter.
module tb_uart_tx_buffer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int G      = 8;
    localparam int HOLD   = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            ovf_clr;
    logic            tx_status;
    logic            tx_ready;
    logic [7:0]      tx_byte;

    logic force_status;
    logic xm_status;
    logic xm_en;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] got_q[$];
    int         rise_q[$];
    int         fall_q[$];
    logic [7:0] exp_q[$];

    assign tx_status = force_status | xm_status;

    uart_tx_buffer #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .GAP_CYCLES (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .tx_status (tx_status),
        .tx_ready  (tx_ready),
        .tx_byte   (tx_byte)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy 5 clk after seeing tx_ready, for HOLD clk.
    initial begin
        xm_status = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (xm_en && tx_ready) begin
                rise_q.push_back(cyc);
                got_q.push_back(tx_byte);
                repeat (5) begin @(posedge clk); #1; end
                xm_status = 1'b1;
                repeat (HOLD) begin @(posedge clk); #1; end
                xm_status = 1'b0;
                fall_q.push_back(cyc);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_min(input string tag, input int obs, input int min);
        tests++;
        assert (obs >= min) else begin
            fails++;
            $error("FAIL %s: observed %0d expected at least %0d", tag, obs, min);
        end
    endtask

    task automatic put(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (tx_ready === 1'b1) ok = 1'b1;
        end
    endtask

    // Wait for n frames beyond the given bases, then compare order and spacing.
    task automatic drain(input string tag, input int gbase, input int rbase, input int fbase, input int n);
        for (int i = 0; i < 4000; i++) begin
            if (got_q.size() >= gbase + n && fall_q.size() >= fbase + n) break;
            tick();
        end
        chk({tag, "_frames"}, got_q.size() - gbase, n);
        for (int i = 0; i < n; i++) begin
            if (got_q.size() > gbase + i) chk({tag, "_byte"}, got_q[gbase + i], exp_q[i]);
        end
        for (int i = 1; i < n; i++) begin
            if (rise_q.size() > rbase + i && fall_q.size() > fbase + i - 1)
                chk_min({tag, "_spacing"}, rise_q[rbase + i] - fall_q[fbase + i - 1], G + 3);
        end
        xm_en = 1'b0;
        repeat (G + 12) tick();
    endtask

    initial begin
        bit ok;
        int gb, rb, fb;
        logic [7:0] b;

        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;
        force_status = 1'b0; xm_en = 1'b0;
        repeat (3) tick();
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        rst = 1'b1;
        repeat (3) tick();

        // Single byte with a hand-driven transmitter.
        put(8'hA5);
        chk("single_count_after_write", count, 1);
        wait_ready(10, ok);
        chk("single_ready_seen", ok, 1'b1);
        chk("single_tx_byte", tx_byte, 8'hA5);
        chk("single_empty_after_pop", empty, 1'b1);
        repeat (5) tick();
        chk("single_ready_held", tx_ready, 1'b1);
        chk("single_byte_held", tx_byte, 8'hA5);
        force_status = 1'b1;
        repeat (3) tick();
        chk("single_ready_fall", tx_ready, 1'b0);
        repeat (97) tick();
        force_status = 1'b0;
        repeat (G + 12) tick();
        chk("single_no_spurious_ready", tx_ready, 1'b0);
        chk("single_empty_end", empty, 1'b1);

        // Burst of four with the transmitter model.
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        gb = got_q.size(); rb = rise_q.size(); fb = fall_q.size();
        xm_en = 1'b1;
        for (int v = 1; v <= 4; v++) put(8'(v));
        drain("burst", gb, rb, fb, 4);

        // Overflow with the transmitter stalled.
        for (int v = 16; v <= 32; v++) put(8'(v));
        chk("ovf_count_full", count, DEPTH);
        chk("ovf_full_flag", full, 1'b1);
        chk("ovf_not_yet", overflow, 1'b0);
        chk("ovf_first_ready", tx_ready, 1'b1);
        chk("ovf_first_byte", tx_byte, 8'h10);
        put(8'h21);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_full_after_drop", full, 1'b1);
        chk("ovf_count_after_drop", count, DEPTH);
        ovf_clr = 1'b1;
        put(8'h22);
        ovf_clr = 1'b0;
        chk("ovf_set_beats_clear", overflow, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);
        exp_q = {};
        for (int v = 16; v <= 32; v++) exp_q.push_back(8'(v));
        gb = got_q.size(); rb = rise_q.size(); fb = fall_q.size();
        xm_en = 1'b1;
        drain("ovf_drain", gb, rb, fb, 17);

        // Random bytes with random write gaps; leaves pointers at slot 14.
        exp_q = {};
        gb = got_q.size(); rb = rise_q.size(); fb = fall_q.size();
        xm_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            put(b);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain("random", gb, rb, fb, 8);

        // Push coinciding with pop while the FIFO wraps across slot 15->0.
        exp_q = {};
        for (int i = 0; i < 4; i++) exp_q.push_back(8'($urandom_range(0, 255)));
        force_status = 1'b1;
        repeat (4) tick();
        put(exp_q[0]); put(exp_q[1]); put(exp_q[2]);
        chk("pp_count_three", count, 3);
        chk("pp_held_idle", tx_ready, 1'b0);
        force_status = 1'b0;
        repeat (2) tick();
        chk("pp_ready_before_pop", tx_ready, 1'b0);
        put(exp_q[3]);
        chk("pp_count_unchanged", count, 3);
        chk("pp_ready_at_pop", tx_ready, 1'b1);
        chk("pp_byte_at_pop", tx_byte, exp_q[0]);
        gb = got_q.size(); rb = rise_q.size(); fb = fall_q.size();
        xm_en = 1'b1;
        drain("pp_wrap", gb, rb, fb, 4);

        // Reset in the middle of a request with five bytes queued.
        for (int i = 0; i < 6; i++) put(8'($urandom_range(0, 255)));
        chk("mid_count_five", count, 5);
        chk("mid_in_req", tx_ready, 1'b1);
        rst = 1'b0;
        force_status = 1'b1;
        #1;
        chk("mid_async_ready", tx_ready, 1'b0);
        chk("mid_async_count", count, 0);
        chk("mid_async_empty", empty, 1'b1);
        chk("mid_async_overflow", overflow, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (4) tick();
        put(8'h5A);
        repeat (10) tick();
        chk("mid_wait_busy_ready", tx_ready, 1'b0);
        chk("mid_wait_busy_count", count, 1);
        force_status = 1'b0;
        wait_ready(8, ok);
        chk("mid_resume_ready", ok, 1'b1);
        chk("mid_resume_byte", tx_byte, 8'h5A);
        exp_q = '{8'h5A};
        gb = got_q.size(); rb = rise_q.size(); fb = fall_q.size();
        xm_en = 1'b1;
        drain("mid_drain", gb, rb, fb, 1);

        // Write into an empty FIFO: pop no earlier than the next clock.
        put(8'h3C);
        chk("wtp_no_write_through", tx_ready, 1'b0);
        chk("wtp_count_one", count, 1);
        tick();
        chk("wtp_ready", tx_ready, 1'b1);
        chk("wtp_byte", tx_byte, 8'h3C);
        chk("wtp_empty", empty, 1'b1);
        exp_q = '{8'h3C};
        gb = got_q.size(); rb = rise_q.size(); fb = fall_q.size();
        xm_en = 1'b1;
        drain("wtp_drain", gb, rb, fb, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Transmit-side front end sitting directly upstream of the UART transmitter, in the 100 MHz `clk` domain.
- Accepts bytes from the host through a write-enable/full interface and buffers them in a FIFO.
- Presents one byte at a time to the transmitter using the transmitter's ready-level / `tx_status` handshake. Host writes never wait on the serial line.
- Also provides the cross-domain synchronisation of `tx_status` (bclk domain) and the inter-frame gap that the transmitter's ready edge detector needs.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).
- GAP_CYCLES, 32768, clk cycles `tx_ready` is held low between frames. Must exceed 3 bclk periods: 3 x 10417 = 31251 at 9600 baud.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset, asynchronous and active-low (asserted at 0). Single clock domain `clk`.
- wr_en  input  1  host write strobe; one byte per cycle.
- wr_data  input  8  host byte.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a write is dropped.
- ovf_clr  input  1  clears `overflow`.
- tx_status  input  1  transmitter busy flag, from the bclk domain (asynchronous to clk).
- tx_ready  output  1  request level to the transmitter.
- tx_byte  output  8  byte presented to the transmitter.

Behaviour:
- **Reset (rst=0):**
  - full=0, empty=1, count=0, overflow=0, tx_ready=0, tx_byte=8'h00.
  - Pointers and gap counter cleared; FSM in IDLE; synchroniser flops cleared to 0.
  - Reset takes effect immediately; `tx_ready` drops asynchronously even mid-frame.
- **tx_status synchroniser:**
  - Two flops on clk produce `stat_s`.
  - All FSM decisions use `stat_s`, which lags `tx_status` by 2-3 clk.
- **FIFO writes:**
  - wr_en=1 and count<DEPTH: store at wr_ptr, wr_ptr+1 mod DEPTH.
  - wr_en=1 and count==DEPTH: byte dropped and overflow set. This holds even if a pop occurs in the same cycle; `full` is evaluated before the pop.
  - ovf_clr=1 clears `overflow`. If ovf_clr and a dropped write coincide, set wins.
- **FIFO pop:**
  - Occurs only on the FSM transition IDLE->REQ.
  - Data written while empty becomes poppable the next cycle (no write-through).
- **Count:**
  - Simultaneous push and pop leave count unchanged.
  - Pointers wrap naturally at ADDR_W bits.
  - full = (count==DEPTH); empty = (count==0).
- **FSM states and transitions:**
  - IDLE: tx_ready=0. If count!=0 and stat_s==0: pop, load tx_byte from mem[rd_ptr], go to REQ.
  - REQ: tx_ready=1, tx_byte held stable. When stat_s==1, go to BUSY. The transmitter latches data in LOAD before tx_status rises, so holding until stat_s=1 is sufficient.
  - BUSY: tx_ready=0. When stat_s==0 (frame finished), load gap counter with GAP_CYCLES-1 and go to GAP.
  - GAP: tx_ready=0. Counter decrements each clk. At 0, go to IDLE.
- **tx_byte:** only changes on IDLE->REQ; otherwise holds its last value.
- **Minimum spacing:** from one stat_s fall to the next tx_ready rise is GAP_CYCLES+1 clk.
- **Start-up after reset:** IDLE waits for stat_s==0, so a transmitter still mid-frame is never re-requested.
- **No watchdog:** if tx_status never rises, REQ persists indefinitely. The bench must not treat this as an error unless the transmitter is held in reset.

Decomposition:
- Shared package/header holds the FSM state encodings (IDLE=0, REQ=1, BUSY=2, GAP=3) and the default GAP_CYCLES per baud selection:
  - 9600: 32768
  - 19200: 16384
  - 57600: 8192
  - 115200: 4096
- One sub-module is natural: `sync_fifo` (parameters DEPTH, ADDR_W; ports wr_en, wr_data, rd_en, rd_data, full, empty, count, overflow).
- Top level holds the synchroniser, the FSM and the gap counter.

Test Plan:
- **Single byte:** reset, then write 8'hA5 once; transmitter model raises tx_status 5 clk after tx_ready=1 and holds it 100 clk.
  - tx_byte=8'hA5 while tx_ready=1; empty=1 one cycle after the pop.
  - tx_ready falls within 3 clk of tx_status rising.
- **Burst and gap:** write 8'h01..8'h04 on consecutive cycles (count reaches 4).
  - Bytes presented in order 01,02,03,04.
  - Each tx_ready rise occurs no earlier than GAP_CYCLES+1 clk after the previous stat_s fall (use GAP_CYCLES=8 for sim).
- **Overflow:** with the transmitter stalled (tx_status=0, no response), write 17 bytes 8'h10..8'h20 with DEPTH=16.
  - First byte 8'h10 popped into tx_byte; writes continue to fill the FIFO.
  - The write finding count==16 is dropped, overflow=1, full=1.
  - ovf_clr pulse returns overflow to 0.
- **Simultaneous push/pop:** count=3; wr_en coincides with the IDLE->REQ pop.
  - count stays 3; wr_ptr and rd_ptr both advance; wrap across index 15->0 verified with DEPTH=16.
- **Reset mid-frame:** assert rst=0 while in REQ with 5 bytes queued.
  - tx_ready=0 immediately (asynchronously); count=0, empty=1, overflow=0.
  - After release with tx_status still 1, FSM stays IDLE until tx_status falls.
- **Empty write-then-pop:** empty FIFO, write 8'h3C.
  - Pop occurs no earlier than the following clk.
  - tx_byte=8'h3C; no spurious tx_ready while empty.
